// File: rtl/lsu_pkg.sv
// Shared types and memi field layout for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } lsu_size_t;

    // memi = {unsigned, -, size[1:0], read}
    localparam int MEMI_RD    = 0;
    localparam int MEMI_SZ_LO = 1;
    localparam int MEMI_SZ_HI = 2;
    localparam int MEMI_US    = 4;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / replicated data / legality,
// and load data extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  req_off_i,
    input  lsu_size_t   req_size_i,
    input  logic [31:0] req_wd_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wd_o,
    output logic        req_illegal_o,
    input  logic [1:0]  ld_off_i,
    input  lsu_size_t   ld_size_i,
    input  logic        ld_us_i,
    input  logic [31:0] ld_word_i,
    output logic [31:0] ld_data_o
);

    function automatic logic [31:0] extend_load(input logic [31:0] w,
                                                input lsu_size_t sz,
                                                input logic us);
        logic signed [31:0] s;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = w[7:0];
        h = w[15:0];
        case (sz)
            SZ_B: begin
                if (us) s = $signed({24'd0, w[7:0]});
                else    s = b;
            end
            SZ_H: begin
                if (us) s = $signed({16'd0, w[15:0]});
                else    s = h;
            end
            default: s = $signed(w);
        endcase
        return $unsigned(s);
    endfunction

    always_comb begin
        req_be_o      = 4'hF;
        req_wd_o      = req_wd_i;
        req_illegal_o = 1'b0;
        case (req_size_i)
            SZ_B: begin
                req_be_o = 4'b0001 << req_off_i;
                req_wd_o = {4{req_wd_i[7:0]}};
            end
            SZ_H: begin
                req_be_o      = 4'b0011 << {req_off_i[1], 1'b0};
                req_wd_o      = {2{req_wd_i[15:0]}};
                req_illegal_o = req_off_i[0];
            end
            SZ_W:    req_illegal_o = |req_off_i;
            default: req_illegal_o = 1'b1;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign ld_data_o = extend_load(ld_word_i >> {ld_off_i, 3'b000}, ld_size_i, ld_us_i);

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: IDLE/REQ/DONE handshake to a variable-latency data bus.
// Define LSU_TIMEOUT_EN to abort REQ after TIMEOUT_CYCLES without mem_ready_i.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    input  logic [4:0]  core_memi_i,
    input  logic        core_we_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rd_i
);

    lsu_state_t  state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wd_q, wd_d;
    logic        we_q, we_d;
    logic [1:0]  off_q, off_d;
    lsu_size_t   size_q, size_d;
    logic        us_q, us_d;
    logic [31:0] rd_q, rd_d;
    logic        err_q, err_d;

    logic        access;
    lsu_size_t   core_size;
    logic [3:0]  al_be;
    logic [31:0] al_wd;
    logic        al_illegal;
    logic [31:0] ld_data;
    logic        unused_memi_bit3;

    assign access           = core_we_i | core_memi_i[MEMI_RD];
    assign core_size        = lsu_size_t'(core_memi_i[MEMI_SZ_HI:MEMI_SZ_LO]);
    assign unused_memi_bit3 = core_memi_i[3];

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    lsu_align u_align (
        .req_off_i     (core_addr_i[1:0]),
        .req_size_i    (core_size),
        .req_wd_i      (core_wd_i),
        .req_be_o      (al_be),
        .req_wd_o      (al_wd),
        .req_illegal_o (al_illegal),
        .ld_off_i      (off_q),
        .ld_size_i     (size_q),
        .ld_us_i       (us_q),
        .ld_word_i     (mem_rd_i),
        .ld_data_o     (ld_data)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        we_d    = we_q;
        off_d   = off_q;
        size_d  = size_q;
        us_d    = us_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (al_illegal) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rd_d    = '0;
                    end else begin
                        state_d = REQ;
                        addr_d  = core_addr_i[31:2];
                        be_d    = al_be;
                        wd_d    = al_wd;
                        we_d    = core_we_i;
                        off_d   = core_addr_i[1:0];
                        size_d  = core_size;
                        us_d    = core_memi_i[MEMI_US];
`ifdef LSU_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (mem_ready_i) begin
                    // Stores complete without disturbing the last load result.
                    if (!we_q) rd_d = ld_data;
                    state_d = DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rd_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            size_q  <= SZ_B;
            us_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            off_q   <= off_d;
            size_q  <= size_d;
            us_q    <= us_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Stall is gated by reset so it drops immediately even if the core keeps requesting.
    assign core_stall_o = rst_ni & (((state_q == IDLE) & access) | (state_q == REQ));
    assign mem_req_o    = (state_q == REQ);
    assign mem_we_o     = mem_req_o & we_q;
    assign mem_be_o     = mem_req_o ? be_q : 4'b0000;
    assign mem_addr_o   = {addr_q, 2'b00};
    assign mem_wd_o     = wd_q;
    assign core_rd_o    = rd_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed self-checking bench for lsu_mem_if (timeout case only with LSU_TIMEOUT_EN).
module tb_lsu_mem_if;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] core_addr_i, core_wd_i, core_rd_o;
    logic [4:0]  core_memi_i;
    logic        core_we_i, core_stall_o, err_o;
    logic        mem_req_o, mem_we_o, mem_ready_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    lsu_mem_if #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_memi_i  (core_memi_i),
        .core_we_i    (core_we_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_ready_i  (mem_ready_i),
        .mem_rd_i     (mem_rd_i)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic set_idle();
        core_addr_i = '0;
        core_wd_i   = '0;
        core_memi_i = '0;
        core_we_i   = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    // Called just after a posedge with the DUT in IDLE; returns after the DONE cycle.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wd,
                             input logic [4:0] memi, input logic we,
                             input logic [31:0] rword, input int delay,
                             output int stall_n, output int req_n, output int unstable,
                             output logic [31:0] b_addr, output logic [31:0] b_wd,
                             output logic [3:0] b_be, output logic b_we,
                             output logic d_err, output logic [31:0] d_rd);
        logic timed_out;
        core_addr_i = addr;
        core_wd_i   = wd;
        core_memi_i = memi;
        core_we_i   = we;
        mem_rd_i    = rword;
        mem_ready_i = 1'b0;
        stall_n = 0; req_n = 0; unstable = 0;
        b_addr = '0; b_wd = '0; b_be = '0; b_we = 1'b0;
        d_err = 1'b0; d_rd = '0;
        timed_out = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (!core_stall_o) begin
                timed_out = 1'b0;
                d_err = err_o;
                d_rd  = core_rd_o;
                break;
            end
            stall_n++;
            if (mem_req_o) begin
                req_n++;
                if (req_n == 1) begin
                    b_addr = mem_addr_o; b_wd = mem_wd_o; b_be = mem_be_o; b_we = mem_we_o;
                end else if (mem_addr_o !== b_addr || mem_wd_o !== b_wd ||
                             mem_be_o !== b_be || mem_we_o !== b_we) begin
                    unstable++;
                end
                mem_ready_i = (req_n > delay);
            end else begin
                mem_ready_i = 1'b0;
            end
        end
        check("access_bound", 32'(timed_out), 32'd0);
        @(posedge clk_i);
        #1;
        set_idle();
    endtask

    int          st, rq, us;
    logic [31:0] ba, bw, rd;
    logic [3:0]  bb;
    logic        bwe, er;

    initial begin
        rst_ni   = 1'b0;
        mem_rd_i = '0;
        set_idle();
        @(negedge clk_i);
        check("rst_stall", 32'(core_stall_o), 0);
        check("rst_req",   32'(mem_req_o), 0);
        check("rst_rd",    core_rd_o, 0);
        check("rst_err",   32'(err_o), 0);
        check("rst_addr",  mem_addr_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // LW 0x100
        do_access(32'h100, 32'h0, 5'b00101, 1'b0, 32'hCAFEBABE, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("lw_stall", 32'(st), 2);
        check("lw_req", 32'(rq), 1);
        check("lw_addr", ba, 32'h100);
        check("lw_be", 32'(bb), 32'hF);
        check("lw_we", 32'(bwe), 0);
        check("lw_rd", rd, 32'hCAFEBABE);
        check("lw_err", 32'(er), 0);

        // LB / LBU at 0x103
        do_access(32'h103, 32'h0, 5'b00001, 1'b0, 32'h80FF0000, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("lb_addr", ba, 32'h100);
        check("lb_be", 32'(bb), 32'h8);
        check("lb_rd", rd, 32'hFFFFFF80);
        do_access(32'h103, 32'h0, 5'b10001, 1'b0, 32'h80FF0000, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("lbu_rd", rd, 32'h00000080);

        // SH 0x0A
        do_access(32'h0A, 32'h1234ABCD, 5'b00010, 1'b1, 32'hDEADBEEF, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("sh_stall", 32'(st), 2);
        check("sh_addr", ba, 32'h08);
        check("sh_be", 32'(bb), 32'hC);
        check("sh_wd", bw, 32'hABCDABCD);
        check("sh_we", 32'(bwe), 1);
        check("sh_rd_kept", rd, 32'h00000080);

        // LH / LHU at 0x102
        do_access(32'h102, 32'h0, 5'b00011, 1'b0, 32'h80011234, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("lh_be", 32'(bb), 32'hC);
        check("lh_rd", rd, 32'hFFFF8001);
        do_access(32'h102, 32'h0, 5'b10011, 1'b0, 32'h80011234, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("lhu_rd", rd, 32'h00008001);

        // SB 0x101
        do_access(32'h101, 32'h00000055, 5'b00000, 1'b1, 32'h0, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("sb_be", 32'(bb), 32'h2);
        check("sb_wd", bw, 32'h55555555);

        // SW with ready after 5 waiting REQ cycles: 6 REQ cycles plus the IDLE cycle
        do_access(32'h200, 32'h11223344, 5'b00100, 1'b1, 32'h0, 5, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("swd_req", 32'(rq), 6);
        check("swd_stall", 32'(st), 7);
        check("swd_stable", 32'(us), 0);
        check("swd_addr", ba, 32'h200);
        check("swd_wd", bw, 32'h11223344);
        check("swd_be", 32'(bb), 32'hF);
        check("swd_rd_kept", rd, 32'h00008001);

        // mem_ready_i while idle must be ignored
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'hFFFFFFFF;
        repeat (3) @(negedge clk_i);
        check("idle_rdy_rd", core_rd_o, 32'h00008001);
        check("idle_rdy_req", 32'(mem_req_o), 0);
        check("idle_rdy_be", 32'(mem_be_o), 0);
        @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0;

        // Misaligned LW 0x102
        do_access(32'h102, 32'h0, 5'b00101, 1'b0, 32'h12345678, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("mis_stall", 32'(st), 1);
        check("mis_req", 32'(rq), 0);
        check("mis_err", 32'(er), 1);
        check("mis_rd", rd, 0);
        @(negedge clk_i);
        check("mis_err_pulse", 32'(err_o), 0);
        @(posedge clk_i);
        #1;

        // Reserved size
        do_access(32'h0, 32'h0, 5'b00111, 1'b0, 32'h12345678, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("rsvd_err", 32'(er), 1);
        check("rsvd_req", 32'(rq), 0);

        // Load something nonzero, then reset in the middle of a stalled SW
        do_access(32'h100, 32'h0, 5'b00101, 1'b0, 32'hCAFEBABE, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        core_addr_i = 32'h200; core_wd_i = 32'h11223344; core_memi_i = 5'b00100; core_we_i = 1'b1;
        mem_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rstmid_req_before", 32'(mem_req_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        check("rstmid_req", 32'(mem_req_o), 0);
        check("rstmid_stall", 32'(core_stall_o), 0);
        check("rstmid_be", 32'(mem_be_o), 0);
        check("rstmid_addr", mem_addr_o, 0);
        check("rstmid_wd", mem_wd_o, 0);
        check("rstmid_rd", core_rd_o, 0);
        @(negedge clk_i);
        set_idle();
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

`ifdef LSU_TIMEOUT_EN
        do_access(32'h100, 32'h0, 5'b00101, 1'b0, 32'hCAFEBABE, 0, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("to_pre_rd", rd, 32'hCAFEBABE);
        do_access(32'h300, 32'h0, 5'b00101, 1'b0, 32'h0, 1000, st, rq, us, ba, bw, bb, bwe, er, rd);
        check("to_req", 32'(rq), 8);
        check("to_err", 32'(er), 1);
        check("to_rd", rd, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
